// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported, variable-latency memory between instruction fetch
// (IF) and data load/store (DM). One access is in flight at a time. Data wins
// contention unless fetch has already lost STARVE_LIMIT consecutive grants,
// in which case fetch is forced through.
//
// Ports:
//   clk, startin                 clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request, held until if_ack
//   if_rdata/if_ack              fetched word (held) and one-cycle completion
//   dm_req/dm_we/dm_addr/dm_wdata data request, held until dm_ack
//   dm_rdata/dm_ack              load data (held) and one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata  memory strobe and latched access fields
//   mem_rdata/mem_ready          memory response, sampled only while mem_req=1
//   stall_if/stall_mem           request pending and not completing this cycle
//   busy                         arbiter not idle
//
// state   | meaning
// IDLE    | no access; requests arbitrated here
// BUSY_IF | fetch access in flight, waiting for mem_ready
// BUSY_DM | data access in flight, waiting for mem_ready
// DONE_IF | if_ack cycle
// DONE_DM | dm_ack cycle
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        DONE_IF = 3'd3,
        DONE_DM = 3'd4
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [3:0]        streak, streak_nxt;
    logic              grant_if, grant_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state  <= IDLE;
            streak <= 4'd0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && (!if_req || streak < LIMIT)) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUSY_DM;
                    // streak counts data grants that fetch had to watch go by
                    if (if_req)
                        streak_nxt = (streak < LIMIT) ? streak + 4'd1 : LIMIT;
                    else
                        streak_nxt = 4'd0;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_nxt  = BUSY_IF;
                    streak_nxt = 4'd0;
                end
            end
            BUSY_IF: if (mem_ready) state_nxt = DONE_IF;
            BUSY_DM: if (mem_ready) state_nxt = DONE_DM;
            DONE_IF: state_nxt = IDLE;
            DONE_DM: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access fields are captured at grant so later request changes cannot
    // disturb an access already on the memory bus.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_dm) begin
            lat_we    <= dm_we;
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
        end else if (grant_if) begin
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (mem_ready) begin
            if (state == BUSY_IF)
                if_rdata <= mem_rdata;
            if (state == BUSY_DM && !lat_we)
                dm_rdata <= mem_rdata;
        end
    end

    assign mem_req   = (state == BUSY_IF) || (state == BUSY_DM);
    assign mem_we    = mem_req & lat_we;
    assign mem_addr  = mem_req ? lat_addr : '0;
    assign mem_wdata = mem_req ? lat_wdata : '0;
    assign if_ack    = (state == DONE_IF);
    assign dm_ack    = (state == DONE_DM);
    assign busy      = (state != IDLE);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    localparam int P_FREE   = 0;
    localparam int P_ACCESS = 1;
    localparam int P_ACK    = 2;
    localparam int O_IF     = 1;
    localparam int O_DM     = 2;

    logic          clk = 1'b0;
    logic          startin = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .startin(startin),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: one access at a time, described as
    // free -> access in progress -> acknowledge -> free.
    int            m_phase;
    int            m_owner;
    int            m_streak;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_dm_rdata;

    int   obs_grants[$];
    logic prev_mem_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = P_FREE;
        m_owner    = 0;
        m_streak   = 0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
    endtask

    // Applies the arbitration rules to the inputs present at the coming edge.
    task automatic model_advance();
        if (!startin) begin
            model_reset();
        end else if (m_phase == P_FREE) begin
            if (dm_req && (!if_req || m_streak < SL)) begin
                m_owner  = O_DM;
                m_we     = dm_we;
                m_addr   = dm_addr;
                m_wdata  = dm_wdata;
                m_streak = if_req ? m_streak + 1 : 0;
                m_phase  = P_ACCESS;
            end else if (if_req) begin
                m_owner  = O_IF;
                m_we     = 1'b0;
                m_addr   = if_addr;
                m_wdata  = '0;
                m_streak = 0;
                m_phase  = P_ACCESS;
            end
        end else if (m_phase == P_ACCESS) begin
            if (mem_ready) begin
                if (m_owner == O_IF)
                    m_if_rdata = mem_rdata;
                else if (!m_we)
                    m_dm_rdata = mem_rdata;
                m_phase = P_ACK;
            end
        end else begin
            m_phase = P_FREE;
        end
    endtask

    function automatic logic exp_if_ack();
        return (m_phase == P_ACK) && (m_owner == O_IF);
    endfunction

    function automatic logic exp_dm_ack();
        return (m_phase == P_ACK) && (m_owner == O_DM);
    endfunction

    task automatic check_outputs();
        logic acc;
        acc = (m_phase == P_ACCESS);
        chk("mem_req", 32'(mem_req), 32'(acc));
        if (acc) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", 32'(if_ack), 32'(exp_if_ack()));
        chk("dm_ack", 32'(dm_ack), 32'(exp_dm_ack()));
        chk("stall_if", 32'(stall_if), 32'(if_req & ~exp_if_ack()));
        chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~exp_dm_ack()));
        chk("busy", 32'(busy), 32'(m_phase != P_FREE));
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("dm_rdata", dm_rdata, m_dm_rdata);
    endtask

    task automatic tick();
        model_advance();
        @(negedge clk);
        check_outputs();
        if (mem_req && !prev_mem_req)
            obs_grants.push_back(int'(mem_addr[15:12]));
        prev_mem_req = mem_req;
    endtask

    initial begin
        int cnt_req;
        int cnt_ack;
        int stall_gap;
        int first_seen;
        int ack_times[$];
        int exp_order[6];

        exp_order = '{2, 2, 2, 2, 1, 2};
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check_outputs();
        startin = 1'b1;

        // single load
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("load_c1_mem_req", 32'(mem_req), 32'd1);
        chk("load_c1_mem_addr", mem_addr, 32'h40);
        tick();
        chk("load_c2_dm_ack", 32'(dm_ack), 32'd1);
        dm_req = 1'b0;
        mem_rdata = 32'h0;
        tick(); tick();
        chk("load_rdata_held", dm_rdata, 32'hDEADBEEF);

        // store with three wait cycles
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234;
        mem_ready = 1'b0;
        cnt_req = 0; cnt_ack = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (mem_req) cnt_req++;
            if (dm_ack) begin cnt_ack++; dm_req = 1'b0; end
            mem_ready = (i >= 4);
        end
        chk("store_memreq_cycles", cnt_req, 32'd4);
        chk("store_ack_count", cnt_ack, 32'd1);
        chk("store_rdata_kept", dm_rdata, 32'hDEADBEEF);

        // contention with both requesters held
        obs_grants.delete();
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        mem_ready = 1'b1;
        stall_gap = 0; first_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (first_seen == 0) begin
                if (if_ack) first_seen = 1;
                else if (stall_if !== 1'b1) stall_gap++;
            end
            if (if_ack) if_addr = if_addr + 32'd4;
            if (dm_ack) dm_addr = dm_addr + 32'd4;
            mem_rdata = $urandom;
        end
        chk("contention_if_served", first_seen, 32'd1);
        chk("contention_stall_if_gap", stall_gap, 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k < obs_grants.size())
                chk($sformatf("grant_order_%0d", k), obs_grants[k], exp_order[k]);
            else
                chk($sformatf("grant_order_%0d", k), 32'hFFFF_FFFF, exp_order[k]);
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (5) tick();

        // fetch only, renewed after each ack
        if_req = 1'b1; if_addr = 32'h0;
        mem_ready = 1'b1;
        ack_times.delete();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("fetch_mem_we", 32'(mem_we), 32'd0);
            if (if_ack) begin
                ack_times.push_back(i);
                if (if_addr == 32'h8) if_req = 1'b0;
                else if_addr = if_addr + 32'd4;
            end
            mem_rdata = $urandom;
        end
        chk("fetch_ack_count", ack_times.size(), 32'd3);
        if (ack_times.size() == 3) begin
            chk("fetch_spacing_1", ack_times[1] - ack_times[0], 32'd3);
            chk("fetch_spacing_2", ack_times[2] - ack_times[1], 32'd3);
        end

        // reset during a data access
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0;
        tick(); tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 startin = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dm_ack", 32'(dm_ack), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        model_reset();
        dm_req = 1'b0;
        tick();
        startin = 1'b1;
        mem_ready = 1'b1;
        repeat (3) tick();
        dm_req = 1'b1; dm_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
        cnt_ack = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dm_ack) begin cnt_ack++; dm_req = 1'b0; end
        end
        chk("post_reset_ack_count", cnt_ack, 32'd1);
        chk("post_reset_rdata", dm_rdata, 32'hCAFEF00D);

        // idle
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(1));
            tick();
            chk("idle_mem_req", 32'(mem_req), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_stalls", 32'({stall_if, stall_mem}), 32'd0);
        end

        // randomized traffic against the reference
        for (int c = 0; c < 1500; c++) begin
            if (!if_req || exp_if_ack()) begin
                if_req  = ($urandom_range(99) < 60);
                if_addr = 32'($urandom_range(255)) << 2;
            end
            if (!dm_req || exp_dm_ack()) begin
                dm_req   = ($urandom_range(99) < 60);
                dm_we    = 1'($urandom_range(1));
                dm_addr  = 32'($urandom_range(255)) << 2;
                dm_wdata = $urandom;
            end
            mem_ready = ($urandom_range(2) == 0);
            mem_rdata = $urandom;
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Registered FSM; one grant at a time, data-first priority with a starvation limit for fetch.
- Produces per-requester stall signals so the pipeline control can freeze PC/IF_ID (fetch) or the whole pipeline (data).

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
STARVE_LIMIT, 4, max consecutive data grants while fetch waits before fetch is forced (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
startin  in  1  asynchronous reset, active-low
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid with if_ack, held until next fetch ack
if_ack  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid with dm_ack, held until next load ack
dm_ack  out  1  one-cycle completion pulse for data
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion, sampled only while mem_req=1
stall_if  out  1  if_req & ~if_ack
stall_mem  out  1  dm_req & ~dm_ack
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (startin=0, async): state IDLE, streak=0, all outputs 0 including if_rdata/dm_rdata; an in-flight access is abandoned; mem_req drops immediately.
- States: IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM.
- IDLE, no request: stay.
- IDLE, grant to DM when dm_req=1 and (if_req=0 or streak<STARVE_LIMIT); else grant to IF when if_req=1.
- On grant, latch addr/we/wdata into registers (IF grant: mem_we=0, mem_wdata=0). Go to BUSY_x.
- BUSY_x: mem_req=1; mem_addr/mem_we/mem_wdata come from latched registers and are stable for the whole access.
  - mem_ready=1: capture mem_rdata (DM load only; stores leave dm_rdata unchanged) and go to DONE_x.
  - mem_ready=0: stay, with no timeout.
- DONE_x: x_ack=1 for exactly this cycle, mem_req=0, go to IDLE. Requests are not evaluated in DONE; the requester drops or renews req at the edge ending the ack cycle.
- Minimum latency: req seen at edge 0, mem_req high cycle 1, ack in cycle 2 if mem_ready=1 in cycle 1. Back-to-back accesses from one requester occur every 3 cycles minimum.
- Streak counter (4 bits) updates at the grant edge:
  - DM grant with if_req=1: streak+1, saturating at STARVE_LIMIT.
  - DM grant with if_req=0: streak=0.
  - IF grant: streak=0.
- Simultaneous if_req and dm_req with streak<STARVE_LIMIT: DM wins. With streak==STARVE_LIMIT: IF wins.
- stall_if and stall_mem are combinational from inputs and registered acks. Both may be high together.
- Request signal changes while req=1 and before ack are illegal. The arbiter uses latched values only.
- A request dropped before ack while granted still completes the memory access. The ack pulse is still issued and is ignored.

Test Plan:
- Single load: reset, dm_req=1, dm_we=0, dm_addr=0x40, mem_ready=1 with mem_rdata=0xDEADBEEF -> mem_req in cycle 1 with mem_addr=0x40, mem_we=0; dm_ack cycle 2; dm_rdata=0xDEADBEEF held afterward.
- Store with wait: dm_we=1, dm_wdata=0x1234, mem_ready low 3 cycles -> mem_req/mem_we/mem_wdata stable 4 cycles; stall_mem=1 throughout; single dm_ack; dm_rdata unchanged.
- Contention: if_req and dm_req both held continuously, STARVE_LIMIT=4, mem_ready=1 -> grant order DM,DM,DM,DM,IF,DM..., and stall_if=1 until first if_ack.
- Fetch only: if_req with if_addr 0,4,8, each renewed after ack -> if_ack every 3 cycles, if_rdata matches each mem_rdata, mem_we=0 always.
- Reset mid-access: startin low during BUSY_DM -> mem_req, busy and all acks 0 immediately. After release, IDLE with no spurious ack; the next request is served normally.
- Idle: no requests for 10 cycles -> mem_req=0, busy=0, both stalls 0.
